// File: rtl/pwm_seq_ctrl_pkg.sv
// Shared types and table geometry for the PWM sequencer slice.
// Index and length widths are derived once here from the table depth.
package pkg_pwm_seq;

    localparam int SEQ_DEPTH = 8;
    localparam int SEQ_IDX_W = $clog2(SEQ_DEPTH);
    localparam int SEQ_LEN_W = SEQ_IDX_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ARM,
        ST_WAIT_LD,
        ST_HOLD,
        ST_DONE
    } pwm_seq_state_t;

endpackage

// File: rtl/pwm_seq_ctrl_if.sv
// Link between the sequencer and one PWM channel: configuration values and
// the load-trigger request out, period-match and load-complete pulses back.
interface pwm_seq_ctrl_if #(
    parameter int N = 16
);

    logic [N-1:0] cfg_pr;
    logic [N-1:0] cfg_dc;
    logic         ld_trg_set;
    logic         pr_match_event;
    logic         ld_done;

    modport master (
        output cfg_pr,
        output cfg_dc,
        output ld_trg_set,
        input  pr_match_event,
        input  ld_done
    );

    modport slave (
        input  cfg_pr,
        input  cfg_dc,
        input  ld_trg_set,
        output pr_match_event,
        output ld_done
    );

endinterface

// File: rtl/pwm_seq_ctrl_table.sv
// Sequencer entry store: one synchronous write port, one combinational read
// port, so a fetch in the same cycle as a write to that slot sees old data.
module pwm_seq_table
    import pkg_pwm_seq::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = SEQ_DEPTH,
    parameter int RPT_W = 8,
    parameter int IDX_W = SEQ_IDX_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [N-1:0]     wpr,
    input  logic [N-1:0]     wdc,
    input  logic [RPT_W-1:0] wrpt,
    input  logic [IDX_W-1:0] raddr,
    output logic [N-1:0]     rpr,
    output logic [N-1:0]     rdc,
    output logic [RPT_W-1:0] rrpt
);

    logic [N-1:0]     pr_mem  [DEPTH];
    logic [N-1:0]     dc_mem  [DEPTH];
    logic [RPT_W-1:0] rpt_mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pr_mem[i]  <= '0;
                dc_mem[i]  <= '0;
                rpt_mem[i] <= '0;
            end
        end else if (we) begin
            pr_mem[waddr]  <= wpr;
            dc_mem[waddr]  <= wdc;
            rpt_mem[waddr] <= wrpt;
        end
    end

    assign rpr  = pr_mem[raddr];
    assign rdc  = dc_mem[raddr];
    assign rrpt = rpt_mem[raddr];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Table-driven PWM reprogramming sequencer: presents each (period, duty) entry,
// requests a shadow load, then holds it for repeat+1 PWM periods.
module pwm_seq_ctrl
    import pkg_pwm_seq::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = SEQ_DEPTH,
    parameter int RPT_W = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 seq_start,
    input  logic                 seq_stop,
    input  logic                 seq_loop,
    input  logic [SEQ_LEN_W-1:0] seq_len,
    input  logic                 tbl_we,
    input  logic [SEQ_IDX_W-1:0] tbl_addr,
    input  logic [N-1:0]         tbl_wpr,
    input  logic [N-1:0]         tbl_wdc,
    input  logic [RPT_W-1:0]     tbl_wrpt,
    pwm_seq_ctrl_if.master       pwm,
    output logic                 busy,
    output logic [SEQ_IDX_W-1:0] seq_idx,
    output logic                 seq_done,
    output logic                 seq_err
);

    pwm_seq_state_t       state;
    logic [SEQ_IDX_W-1:0] idx;
    logic [SEQ_IDX_W-1:0] last_idx;
    logic                 loop_en;
    logic [RPT_W-1:0]     rpt_q;
    logic [RPT_W-1:0]     cnt;
    logic [N-1:0]         cfg_pr_q;
    logic [N-1:0]         cfg_dc_q;
    logic                 ld_trg_q;
    logic [N-1:0]         rd_pr;
    logic [N-1:0]         rd_dc;
    logic [RPT_W-1:0]     rd_rpt;
    logic                 start_ok;
    logic                 advance;

    pwm_seq_table #(
        .N     (N),
        .DEPTH (DEPTH),
        .RPT_W (RPT_W),
        .IDX_W (SEQ_IDX_W)
    ) u_table (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .we      (tbl_we),
        .waddr   (tbl_addr),
        .wpr     (tbl_wpr),
        .wdc     (tbl_wdc),
        .wrpt    (tbl_wrpt),
        .raddr   (idx),
        .rpr     (rd_pr),
        .rdc     (rd_dc),
        .rrpt    (rd_rpt)
    );

    assign start_ok = (seq_len != '0) && (seq_len <= SEQ_LEN_W'(DEPTH));

    // The load pulse itself is period 1; a match arriving with it is not counted.
    always_comb begin
        advance = 1'b0;
        if (state == ST_WAIT_LD && pwm.ld_done && rpt_q == '0) begin
            advance = 1'b1;
        end
        if (state == ST_HOLD && pwm.pr_match_event && cnt == RPT_W'(1)) begin
            advance = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            last_idx <= '0;
            loop_en  <= 1'b0;
            rpt_q    <= '0;
            cnt      <= '0;
            cfg_pr_q <= '0;
            cfg_dc_q <= '0;
            ld_trg_q <= 1'b0;
            busy     <= 1'b0;
            seq_idx  <= '0;
            seq_done <= 1'b0;
            seq_err  <= 1'b0;
        end else if (seq_stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            ld_trg_q <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            ld_trg_q <= 1'b0;
            seq_done <= 1'b0;
            if (advance) begin
                if (idx != last_idx) begin
                    idx   <= idx + 1'b1;
                    state <= ST_FETCH;
                end else if (loop_en) begin
                    idx   <= '0;
                    state <= ST_FETCH;
                end else begin
                    seq_done <= 1'b1;
                    state    <= ST_DONE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (seq_start) begin
                            if (start_ok) begin
                                last_idx <= SEQ_IDX_W'(seq_len - 1'b1);
                                loop_en  <= seq_loop;
                                idx      <= '0;
                                seq_err  <= 1'b0;
                                busy     <= 1'b1;
                                state    <= ST_FETCH;
                            end else begin
                                seq_err <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        cfg_pr_q <= rd_pr;
                        cfg_dc_q <= rd_dc;
                        rpt_q    <= rd_rpt;
                        seq_idx  <= idx;
                        ld_trg_q <= 1'b1;
                        state    <= ST_ARM;
                    end
                    ST_ARM: state <= ST_WAIT_LD;
                    ST_WAIT_LD: begin
                        if (pwm.ld_done) begin
                            cnt   <= rpt_q;
                            state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (pwm.pr_match_event) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pwm.cfg_pr     = cfg_pr_q;
    assign pwm.cfg_dc     = cfg_dc_q;
    assign pwm.ld_trg_set = ld_trg_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: a small PWM channel model plays the load/match side and
// a scoreboard compares the per-period shadow values with the table walk.
module tb_pwm_seq_ctrl;
    import pkg_pwm_seq::*;

    localparam int N     = 16;
    localparam int DEPTH = SEQ_DEPTH;
    localparam int RPT_W = 8;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic                 seq_start;
    logic                 seq_stop;
    logic                 seq_loop;
    logic [SEQ_LEN_W-1:0] seq_len;
    logic                 tbl_we;
    logic [SEQ_IDX_W-1:0] tbl_addr;
    logic [N-1:0]         tbl_wpr;
    logic [N-1:0]         tbl_wdc;
    logic [RPT_W-1:0]     tbl_wrpt;
    logic                 busy;
    logic [SEQ_IDX_W-1:0] seq_idx;
    logic                 seq_done;
    logic                 seq_err;

    pwm_seq_ctrl_if #(.N(N)) pwm ();

    pwm_seq_ctrl #(
        .N     (N),
        .DEPTH (DEPTH),
        .RPT_W (RPT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .seq_start (seq_start),
        .seq_stop  (seq_stop),
        .seq_loop  (seq_loop),
        .seq_len   (seq_len),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wpr   (tbl_wpr),
        .tbl_wdc   (tbl_wdc),
        .tbl_wrpt  (tbl_wrpt),
        .pwm       (pwm),
        .busy      (busy),
        .seq_idx   (seq_idx),
        .seq_done  (seq_done),
        .seq_err   (seq_err)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int tickNo = 0;
    int trgCount = 0;
    int doneCount = 0;
    int pcnt = 0;
    int perLen = 4;
    int lastMatchTick = 0;
    bit pwmOn = 1'b0;
    bit autoChk = 1'b0;
    bit seenTrg = 1'b0;
    bit trgPend = 1'b0;
    bit shValid = 1'b0;
    logic [N-1:0] shPr;
    logic [N-1:0] shDc;

    logic [N-1:0]     mPr  [DEPTH];
    logic [N-1:0]     mDc  [DEPTH];
    logic [RPT_W-1:0] mRpt [DEPTH];

    int          expIdx  [$];
    logic [31:0] expPer  [$];
    logic [31:0] periods [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One clock: observe outputs at the falling edge, then let the PWM model
    // decide the match/load pulses for the next rising edge.
    task automatic applyStimulus();
        bit trgObs;
        int e;
        @(negedge sys_clk);
        tickNo++;
        trgObs = (pwm.ld_trg_set === 1'b1);
        if (trgObs) begin
            trgCount++;
            if (pwmOn && seenTrg) checkOutput("trg_gap", tickNo - lastMatchTick, 2);
            seenTrg = 1'b1;
            if (autoChk) begin
                if (expIdx.size() == 0) begin
                    checkOutput("trg_extra", trgCount, 0);
                end else begin
                    e = expIdx.pop_front();
                    checkOutput("cfg_pr", pwm.cfg_pr, mPr[e]);
                    checkOutput("cfg_dc", pwm.cfg_dc, mDc[e]);
                    checkOutput("seq_idx", seq_idx, e);
                end
            end
        end
        if (seq_done === 1'b1) doneCount++;
        if (pwmOn) begin
            pwm.pr_match_event = 1'b0;
            pwm.ld_done = 1'b0;
            pcnt++;
            if (pcnt >= perLen) begin
                pcnt = 0;
                pwm.pr_match_event = 1'b1;
                lastMatchTick = tickNo;
                if (shValid) periods.push_back({shPr, shDc});
                if (trgPend) begin
                    pwm.ld_done = 1'b1;
                    trgPend = 1'b0;
                    shPr = pwm.cfg_pr;
                    shDc = pwm.cfg_dc;
                    shValid = 1'b1;
                end
            end
            if (trgObs) trgPend = 1'b1;
        end
    endtask

    task automatic writeEntry(input int a, input logic [N-1:0] pr, input logic [N-1:0] dc,
                              input logic [RPT_W-1:0] rpt);
        tbl_we = 1'b1;
        tbl_addr = SEQ_IDX_W'(a);
        tbl_wpr = pr;
        tbl_wdc = dc;
        tbl_wrpt = rpt;
        applyStimulus();
        tbl_we = 1'b0;
        mPr[a] = pr;
        mDc[a] = dc;
        mRpt[a] = rpt;
    endtask

    task automatic runSeq(input int len, input bit loop, input int nPer);
        int target;
        int cyc;
        int vis;
        int e;
        expPer.delete();
        expIdx.delete();
        periods.delete();
        vis = 0;
        do begin
            e = vis % len;
            for (int r = 0; r <= int'(mRpt[e]); r++) expPer.push_back({mPr[e], mDc[e]});
            expIdx.push_back(e);
            vis++;
        end while (loop ? (expPer.size() < nPer) : (vis < len));
        if (loop) for (int k = 0; k < len; k++) expIdx.push_back((vis + k) % len);
        target = loop ? nPer : expPer.size();

        trgCount = 0; doneCount = 0; seenTrg = 0; trgPend = 0; shValid = 0; pcnt = 0;
        perLen = $urandom_range(3, 6);
        autoChk = 1'b1;
        pwmOn = 1'b1;
        seq_len = SEQ_LEN_W'(len);
        seq_loop = loop;
        seq_start = 1'b1;
        applyStimulus();
        seq_start = 1'b0;
        checkOutput("busy_rise", busy, 1);
        checkOutput("trg_early", pwm.ld_trg_set, 0);
        applyStimulus();
        checkOutput("trg_latency", pwm.ld_trg_set, 1);

        cyc = 0;
        while (periods.size() < target && cyc < 5000) begin
            applyStimulus();
            cyc++;
        end
        checkOutput("period_timeout", periods.size() >= target, 1);
        for (int i = 0; i < target && i < periods.size(); i++)
            checkOutput($sformatf("period%0d", i), periods[i], expPer[i]);

        if (!loop) begin
            repeat (4) applyStimulus();
            checkOutput("seq_done_count", doneCount, 1);
            checkOutput("busy_fall", busy, 0);
            checkOutput("trg_count", trgCount, len);
            checkOutput("entries_left", expIdx.size(), 0);
        end else begin
            checkOutput("loop_no_done", doneCount, 0);
            checkOutput("loop_busy", busy, 1);
            seq_stop = 1'b1;
            applyStimulus();
            seq_stop = 1'b0;
            checkOutput("loop_stop_busy", busy, 0);
        end
        pwmOn = 1'b0;
        pwm.pr_match_event = 1'b0;
        pwm.ld_done = 1'b0;
    endtask

    initial begin
        int rl;
        bit rlp;
        int cyc;
        sys_rst = 1'b1;
        seq_start = 1'b0; seq_stop = 1'b0; seq_loop = 1'b0; seq_len = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_wpr = '0; tbl_wdc = '0; tbl_wrpt = '0;
        pwm.pr_match_event = 1'b0;
        pwm.ld_done = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin mPr[a] = '0; mDc[a] = '0; mRpt[a] = '0; end
        applyStimulus();
        applyStimulus();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cfg_pr", pwm.cfg_pr, 0);
        checkOutput("rst_cfg_dc", pwm.cfg_dc, 0);
        checkOutput("rst_trg", pwm.ld_trg_set, 0);
        checkOutput("rst_idx", seq_idx, 0);
        checkOutput("rst_done", seq_done, 0);
        checkOutput("rst_err", seq_err, 0);
        sys_rst = 1'b0;

        writeEntry(0, 99, 50, 0);
        writeEntry(1, 199, 20, 2);
        runSeq(2, 1'b0, 0);
        runSeq(2, 1'b1, 10);

        // Invalid lengths are rejected and flagged; a valid start clears the flag.
        autoChk = 1'b1; expIdx.delete(); trgCount = 0;
        seq_len = '0; seq_start = 1'b1; applyStimulus(); seq_start = 1'b0;
        checkOutput("err_len0", seq_err, 1);
        checkOutput("err_len0_busy", busy, 0);
        seq_len = 1; seq_start = 1'b1; applyStimulus(); seq_start = 1'b0;
        checkOutput("err_clear", seq_err, 0);
        checkOutput("err_clear_busy", busy, 1);
        seq_stop = 1'b1; applyStimulus(); seq_stop = 1'b0;
        checkOutput("stop_fetch_busy", busy, 0);
        seq_len = SEQ_LEN_W'(DEPTH + 1); seq_start = 1'b1; applyStimulus(); seq_start = 1'b0;
        checkOutput("err_lenmax", seq_err, 1);
        checkOutput("err_lenmax_busy", busy, 0);
        repeat (3) applyStimulus();
        checkOutput("err_no_trg", trgCount, 0);

        // Abort while waiting for the load, then a stop coincident with start.
        expIdx.push_back(0); trgCount = 0; doneCount = 0;
        seq_len = 2; seq_loop = 1'b0; seq_start = 1'b1; applyStimulus(); seq_start = 1'b0;
        applyStimulus();
        applyStimulus();
        seq_stop = 1'b1; applyStimulus(); seq_stop = 1'b0;
        checkOutput("stop_wait_busy", busy, 0);
        repeat (4) applyStimulus();
        checkOutput("stop_wait_trg", trgCount, 1);
        checkOutput("stop_wait_done", doneCount, 0);
        checkOutput("stop_wait_pr", pwm.cfg_pr, mPr[0]);
        checkOutput("stop_wait_dc", pwm.cfg_dc, mDc[0]);
        seq_len = 1; seq_start = 1'b1; seq_stop = 1'b1; applyStimulus();
        seq_start = 1'b0; seq_stop = 1'b0;
        checkOutput("stop_start_busy", busy, 0);
        repeat (3) applyStimulus();
        checkOutput("stop_start_trg", trgCount, 1);
        checkOutput("stop_start_pr", pwm.cfg_pr, mPr[0]);

        // Write slot 1 during its own fetch: old data now, new data next pass.
        writeEntry(0, 10, 5, 0);
        writeEntry(1, 20, 7, 0);
        autoChk = 1'b0;
        seq_len = 2; seq_loop = 1'b1; seq_start = 1'b1; applyStimulus(); seq_start = 1'b0;
        applyStimulus();
        checkOutput("wr_first_pr", pwm.cfg_pr, 10);
        applyStimulus();
        pwm.ld_done = 1'b1; applyStimulus(); pwm.ld_done = 1'b0;
        tbl_we = 1'b1; tbl_addr = 1; tbl_wpr = 30; tbl_wdc = 9; tbl_wrpt = 0;
        applyStimulus();
        tbl_we = 1'b0;
        mPr[1] = 30; mDc[1] = 9; mRpt[1] = 0;
        checkOutput("wr_old_trg", pwm.ld_trg_set, 1);
        checkOutput("wr_old_pr", pwm.cfg_pr, 20);
        checkOutput("wr_old_dc", pwm.cfg_dc, 7);
        checkOutput("wr_old_idx", seq_idx, 1);
        applyStimulus();
        pwm.ld_done = 1'b1; applyStimulus(); pwm.ld_done = 1'b0;
        applyStimulus();
        checkOutput("wr_wrap_pr", pwm.cfg_pr, 10);
        checkOutput("wr_wrap_idx", seq_idx, 0);
        applyStimulus();
        pwm.ld_done = 1'b1; applyStimulus(); pwm.ld_done = 1'b0;
        applyStimulus();
        checkOutput("wr_new_pr", pwm.cfg_pr, 30);
        checkOutput("wr_new_dc", pwm.cfg_dc, 9);
        seq_stop = 1'b1; applyStimulus(); seq_stop = 1'b0;

        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < DEPTH; a++)
                writeEntry(a, N'($urandom), N'($urandom), RPT_W'($urandom_range(0, 3)));
            rl = $urandom_range(1, DEPTH);
            rlp = ($urandom_range(0, 1) == 1);
            runSeq(rl, rlp, $urandom_range(6, 14));
        end

        // Reset while holding an entry; the table must come back empty.
        writeEntry(0, 40, 20, 200);
        expIdx.delete(); expIdx.push_back(0);
        trgCount = 0; doneCount = 0; seenTrg = 0; trgPend = 0; shValid = 0; pcnt = 0; perLen = 4;
        autoChk = 1'b1; pwmOn = 1'b1;
        seq_len = 1; seq_loop = 1'b0; seq_start = 1'b1; applyStimulus(); seq_start = 1'b0;
        cyc = 0;
        while (!shValid && cyc < 100) begin applyStimulus(); cyc++; end
        checkOutput("hold_reach", shValid, 1);
        repeat (3) applyStimulus();
        pwmOn = 1'b0; pwm.pr_match_event = 1'b0; pwm.ld_done = 1'b0;
        sys_rst = 1'b1; applyStimulus(); sys_rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin mPr[a] = '0; mDc[a] = '0; mRpt[a] = '0; end
        checkOutput("hrst_busy", busy, 0);
        checkOutput("hrst_pr", pwm.cfg_pr, 0);
        checkOutput("hrst_dc", pwm.cfg_dc, 0);
        checkOutput("hrst_trg", pwm.ld_trg_set, 0);
        checkOutput("hrst_idx", seq_idx, 0);
        checkOutput("hrst_done", seq_done, 0);
        applyStimulus();
        checkOutput("hrst_no_done", doneCount, 0);
        expIdx.delete(); expIdx.push_back(0);
        seq_len = 1; seq_start = 1'b1; applyStimulus(); seq_start = 1'b0;
        applyStimulus();
        checkOutput("hrst_tbl_trg", pwm.ld_trg_set, 1);
        checkOutput("hrst_tbl_pr", pwm.cfg_pr, 0);
        applyStimulus();
        pwm.ld_done = 1'b1; applyStimulus(); pwm.ld_done = 1'b0;
        applyStimulus();
        checkOutput("hrst_run_done", doneCount, 1);
        checkOutput("hrst_run_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
